// File: rtl/clockgen_multi_if.sv
// ---------------------------------------------------------------------------
// clockgen_multi_if
// Configuration bus of the multi-channel clock generator.
//   cfg_we   : write strobe (one clk per write)
//   cfg_ch   : target channel; values >= NCH are ignored by the generator
//   cfg_div  : period-1 of the target channel (0 is stored as 1)
//   cfg_high : high time of the target channel (only with CLOCKGEN_DUTY_EN)
//   pending  : per-channel flag, shadow configuration not yet applied
// Modports: master = configuration source, slave = clockgen_multi.
// Optional feature macro: CLOCKGEN_DUTY_EN.
// ---------------------------------------------------------------------------
interface clockgen_multi_if #(
    parameter int NCH  = 2,
    parameter int DIVW = 6,
    parameter int CHW  = (NCH > 1) ? $clog2(NCH) : 1
);
    logic            cfg_we;
    logic [CHW-1:0]  cfg_ch;
    logic [DIVW-1:0] cfg_div;
`ifdef CLOCKGEN_DUTY_EN
    logic [DIVW-1:0] cfg_high;
`endif
    logic [NCH-1:0]  pending;

`ifdef CLOCKGEN_DUTY_EN
    modport master (output cfg_we, cfg_ch, cfg_div, cfg_high, input pending);
    modport slave  (input cfg_we, cfg_ch, cfg_div, cfg_high, output pending);
`else
    modport master (output cfg_we, cfg_ch, cfg_div, input pending);
    modport slave  (input cfg_we, cfg_ch, cfg_div, output pending);
`endif
endinterface

// File: rtl/clockgen_multi.sv
// ---------------------------------------------------------------------------
// clockgen_multi
// NCH independent clock channels, each dividing clk by an integer period
// P = cfg_div+1 (2..2^DIVW). Per channel a registered divided clock (phase)
// and a one-clk strobe on every phase rising edge (sync).
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high
//   shift    in   1 = every channel counter holds (phase slips 1 clk/cycle)
//   stretch  in   [NCH] per-channel veto, holds the channel at its wrap point
//   resync   in   pulse, all counters to 0 on the same edge
//   cfg      if   configuration bus (slave modport), carries pending[NCH]
//   phase    out  [NCH] divided clocks, registered
//   sync     out  [NCH] sync strobes, registered
//
// Optional feature macro: CLOCKGEN_DUTY_EN adds a programmable high time
// per channel (cfg_high, clamped to 1..P-1). Without it the high time is
// ceil(P/2).
//
// New configuration is written into a shadow register and only copied to
// the active register when the counter restarts at 0 (wrap or resync), so
// a period/duty change never produces a truncated or stretched pulse.
// ---------------------------------------------------------------------------
module clockgen_multi #(
    parameter int NCH      = 2,
    parameter int DIVW     = 6,
    parameter int DIV_INIT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            shift,
    input  logic [NCH-1:0]  stretch,
    input  logic            resync,
    clockgen_multi_if.slave cfg,
    output logic [NCH-1:0]  phase,
    output logic [NCH-1:0]  sync
);

    // A stored divider of 0 would mean P=1, which cannot toggle.
    localparam logic [DIVW-1:0] DIV_RST = (DIV_INIT == 0) ? DIVW'(1) : DIVW'(DIV_INIT);
`ifdef CLOCKGEN_DUTY_EN
    localparam logic [DIVW-1:0] HIGH_RST = DIVW'((int'(DIV_RST) + 2) / 2);
`endif

    logic [NCH-1:0] w_pend;

    assign cfg.pending = w_pend;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DIVW-1:0] r_cnt;
            logic [DIVW-1:0] r_div_act;
            logic [DIVW-1:0] r_div_shd;
            logic            r_pend;
            logic            r_first;
            logic            r_phase;
            logic            r_sync;
            logic            w_sel;
            logic            w_at_end;
            logic            w_wrap;
            logic            w_load;
            logic [DIVW-1:0] w_div_wr;
            logic [DIVW-1:0] w_cnt_next;
            logic [DIVW:0]   w_high;

            assign w_sel    = cfg.cfg_we && (32'(cfg.cfg_ch) == gi);
            assign w_div_wr = (cfg.cfg_div == '0) ? DIVW'(1) : cfg.cfg_div;
            assign w_at_end = (r_cnt == r_div_act);
            assign w_wrap   = !shift && !stretch[gi] && w_at_end;
            // resync overrides both shift and stretch.
            assign w_load   = resync || w_wrap;

            always_comb begin
                w_cnt_next = r_cnt;
                if (w_load) begin
                    w_cnt_next = '0;
                end else if (!shift && !w_at_end) begin
                    w_cnt_next = r_cnt + DIVW'(1);
                end
            end

`ifdef CLOCKGEN_DUTY_EN
            logic [DIVW-1:0] r_high_act;
            logic [DIVW-1:0] r_high_shd;

            // Clamp is applied at use so a high time stored against one
            // period stays valid if only the period changes later.
            always_comb begin
                w_high = {1'b0, r_high_act};
                if (r_high_act == '0) begin
                    w_high = (DIVW+1)'(1);
                end else if (r_high_act > r_div_act) begin
                    w_high = {1'b0, r_div_act};
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_high_act <= HIGH_RST;
                    r_high_shd <= HIGH_RST;
                end else begin
                    if (w_load) begin
                        r_high_act <= r_high_shd;
                    end
                    if (w_sel) begin
                        r_high_shd <= cfg.cfg_high;
                    end
                end
            end
`else
            // ceil(P/2) with P = div+1, one extra bit for the sum.
            assign w_high = ({1'b0, r_div_act} + (DIVW+1)'(2)) >> 1;
`endif

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt     <= '0;
                    r_div_act <= DIV_RST;
                    r_div_shd <= DIV_RST;
                    r_pend    <= 1'b0;
                    r_first   <= 1'b0;
                    r_phase   <= 1'b0;
                    r_sync    <= 1'b0;
                end else begin
                    r_cnt   <= w_cnt_next;
                    r_first <= w_load;
                    r_phase <= ({1'b0, r_cnt} < w_high);
                    r_sync  <= r_first;
                    // Apply uses the shadow as it was before this edge, so a
                    // write landing on the wrap edge stays pending.
                    if (w_load) begin
                        r_div_act <= r_div_shd;
                    end
                    if (w_sel) begin
                        r_div_shd <= w_div_wr;
                    end
                    if (w_sel) begin
                        r_pend <= 1'b1;
                    end else if (w_load) begin
                        r_pend <= 1'b0;
                    end
                end
            end

            assign phase[gi]  = r_phase;
            assign sync[gi]   = r_sync;
            assign w_pend[gi] = r_pend;
        end
    endgenerate

endmodule

// File: tb/tb_clockgen_multi.sv
// ---------------------------------------------------------------------------
// tb_clockgen_multi
// Directed scenarios followed by a randomized stretch, all checked every
// cycle against an integer reference model of the channel behaviour.
// ---------------------------------------------------------------------------
module tb_clockgen_multi;

    localparam int NCH      = 2;
    localparam int DIVW     = 6;
    localparam int DIV_INIT = 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           shift;
    logic [NCH-1:0] stretch;
    logic           resync;
    logic [NCH-1:0] phase;
    logic [NCH-1:0] sync;

    clockgen_multi_if #(.NCH(NCH), .DIVW(DIVW)) cfg_bus ();

    clockgen_multi #(.NCH(NCH), .DIVW(DIVW), .DIV_INIT(DIV_INIT)) dut (
        .clk     (clk),
        .reset   (reset),
        .shift   (shift),
        .stretch (stretch),
        .resync  (resync),
        .cfg     (cfg_bus.slave),
        .phase   (phase),
        .sync    (sync)
    );

    always #5 clk = ~clk;

    // Reference model: position inside the period, period, shadow period,
    // pending flag, and "restarted on the last edge" flag.
    int m_pos   [NCH];
    int m_P     [NCH];
    int m_shP   [NCH];
    int m_pend  [NCH];
    int m_first [NCH];
`ifdef CLOCKGEN_DUTY_EN
    int m_H     [NCH];
    int m_shH   [NCH];
`endif

    logic [NCH-1:0] exp_phase;
    logic [NCH-1:0] exp_sync;
    logic [NCH-1:0] exp_pend;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    function automatic int eff_high(int i);
`ifdef CLOCKGEN_DUTY_EN
        if (m_H[i] < 1) return 1;
        if (m_H[i] > m_P[i] - 1) return m_P[i] - 1;
        return m_H[i];
`else
        return (m_P[i] + 1) / 2;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_pos[i]   = 0;
            m_P[i]     = ((DIV_INIT == 0) ? 1 : DIV_INIT) + 1;
            m_shP[i]   = m_P[i];
            m_pend[i]  = 0;
            m_first[i] = 0;
`ifdef CLOCKGEN_DUTY_EN
            m_H[i]     = (m_P[i] + 1) / 2;
            m_shH[i]   = m_H[i];
`endif
        end
        exp_phase = '0;
        exp_sync  = '0;
        exp_pend  = '0;
    endtask

    task automatic check_outputs(string tag);
        n_cmp++;
        assert (phase === exp_phase) else begin
            n_err++;
            $error("FAIL %s phase cyc=%0d got=%b exp=%b", tag, cyc, phase, exp_phase);
        end
        n_cmp++;
        assert (sync === exp_sync) else begin
            n_err++;
            $error("FAIL %s sync cyc=%0d got=%b exp=%b", tag, cyc, sync, exp_sync);
        end
        n_cmp++;
        assert (cfg_bus.pending === exp_pend) else begin
            n_err++;
            $error("FAIL %s pending cyc=%0d got=%b exp=%b", tag, cyc, cfg_bus.pending, exp_pend);
        end
    endtask

    // One clock: model the edge from the inputs currently driven, then
    // compare at the following falling edge.
    task automatic step(string tag);
        for (int i = 0; i < NCH; i++) begin
            bit wrap;
            bit load;
            exp_phase[i] = (m_pos[i] < eff_high(i));
            exp_sync[i]  = (m_first[i] != 0);
            wrap = !shift && !stretch[i] && (m_pos[i] == m_P[i] - 1);
            load = resync || wrap;
            if (load) begin
                m_P[i]     = m_shP[i];
`ifdef CLOCKGEN_DUTY_EN
                m_H[i]     = m_shH[i];
`endif
                m_pend[i]  = 0;
                m_pos[i]   = 0;
                m_first[i] = 1;
            end else begin
                m_first[i] = 0;
                if (!shift && m_pos[i] != m_P[i] - 1) m_pos[i]++;
            end
            if (cfg_bus.cfg_we && int'(cfg_bus.cfg_ch) == i) begin
                m_shP[i]  = ((cfg_bus.cfg_div == '0) ? 1 : int'(cfg_bus.cfg_div)) + 1;
`ifdef CLOCKGEN_DUTY_EN
                m_shH[i]  = int'(cfg_bus.cfg_high);
`endif
                m_pend[i] = 1;
            end
            exp_pend[i] = (m_pend[i] != 0);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs(tag);
        $display("cyc=%0d %s sh=%b st=%b rs=%b we=%b phase=%b sync=%b pend=%b",
                 cyc, tag, shift, stretch, resync, cfg_bus.cfg_we, phase, sync, cfg_bus.pending);
    endtask

    task automatic write_cfg(int ch, int div, string tag);
        cfg_bus.cfg_we  = 1'b1;
        cfg_bus.cfg_ch  = 1'(ch);
        cfg_bus.cfg_div = DIVW'(div);
        step(tag);
        cfg_bus.cfg_we  = 1'b0;
    endtask

`ifdef CLOCKGEN_DUTY_EN
    task automatic write_duty(int ch, int div, int high, string tag);
        cfg_bus.cfg_high = DIVW'(high);
        write_cfg(ch, div, tag);
    endtask
`endif

    task automatic wait_applied(int ch, string tag);
        bit done = 0;
        for (int k = 0; k < 80; k++) begin
            if (m_pend[ch] == 0) begin
                done = 1;
                break;
            end
            step(tag);
        end
        n_cmp++;
        assert (done) else begin
            n_err++;
            $error("FAIL %s apply_timeout got=pending exp=applied", tag);
        end
    endtask

    // Counts highs and syncs of one channel over a window of steps.
    task automatic measure(int ch, int len, string tag, output int hi, output int sy);
        hi = 0;
        sy = 0;
        for (int k = 0; k < len; k++) begin
            step(tag);
            hi += int'(phase[ch]);
            sy += int'(sync[ch]);
        end
    endtask

    initial begin
        int hi;
        int sy;
        bit found;

        reset            = 1'b1;
        shift            = 1'b0;
        stretch          = '0;
        resync           = 1'b0;
        cfg_bus.cfg_we   = 1'b0;
        cfg_bus.cfg_ch   = '0;
        cfg_bus.cfg_div  = '0;
`ifdef CLOCKGEN_DUTY_EN
        cfg_bus.cfg_high = '0;
`endif
        model_reset();

        // Reset state
        @(negedge clk);
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Defaults: both channels period 2
        for (int k = 0; k < 10; k++) step("default");

        // Period 5 on ch0, ch1 untouched
        write_cfg(0, 4, "p5_write");
        n_cmp++;
        assert (cfg_bus.pending === 2'b01) else begin
            n_err++;
            $error("FAIL p5_pending got=%b exp=%b", cfg_bus.pending, 2'b01);
        end
        wait_applied(0, "p5_apply");
        measure(0, 10, "p5_run", hi, sy);
        n_cmp++;
        assert (hi === 6) else begin
            n_err++;
            $error("FAIL p5_high got=%0d exp=%0d", hi, 6);
        end
        n_cmp++;
        assert (sy === 2) else begin
            n_err++;
            $error("FAIL p5_sync got=%0d exp=%0d", sy, 2);
        end

        // Shift for 3 clk with P=4 on both channels
        write_cfg(0, 3, "p4_write0");
        write_cfg(1, 3, "p4_write1");
        wait_applied(0, "p4_apply0");
        wait_applied(1, "p4_apply1");
        for (int k = 0; k < 5; k++) step("p4_run");
        shift = 1'b1;
        for (int k = 0; k < 3; k++) step("shift");
        shift = 1'b0;
        for (int k = 0; k < 10; k++) step("after_shift");

        // Stretch ch1 for 4 clk at its wrap point
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (m_pos[1] == m_P[1] - 1) begin
                found = 1;
                break;
            end
            step("stretch_wait");
        end
        n_cmp++;
        assert (found) else begin
            n_err++;
            $error("FAIL stretch_wait_timeout got=not_at_end exp=at_end");
        end
        stretch = 2'b10;
        for (int k = 0; k < 4; k++) step("stretch");
        stretch = 2'b00;
        for (int k = 0; k < 8; k++) step("after_stretch");

        // Resync with pending P=3 / P=7
        write_cfg(0, 2, "rs_write0");
        write_cfg(1, 6, "rs_write1");
        resync = 1'b1;
        step("resync");
        resync = 1'b0;
        step("resync_next");
        n_cmp++;
        assert (sync === 2'b11) else begin
            n_err++;
            $error("FAIL resync_sync got=%b exp=%b", sync, 2'b11);
        end
        n_cmp++;
        assert (cfg_bus.pending === 2'b00) else begin
            n_err++;
            $error("FAIL resync_pending got=%b exp=%b", cfg_bus.pending, 2'b00);
        end
        for (int k = 0; k < 14; k++) step("after_resync");

`ifdef CLOCKGEN_DUTY_EN
        // Duty clamp: high 0 -> 1, high 15 -> 9, period 10
        write_duty(0, 9, 0, "duty_lo");
        wait_applied(0, "duty_lo_apply");
        measure(0, 10, "duty_lo_run", hi, sy);
        n_cmp++;
        assert (hi === 1) else begin
            n_err++;
            $error("FAIL duty_lo_high got=%0d exp=%0d", hi, 1);
        end
        write_duty(0, 9, 15, "duty_hi");
        wait_applied(0, "duty_hi_apply");
        measure(0, 10, "duty_hi_run", hi, sy);
        n_cmp++;
        assert (hi === 9) else begin
            n_err++;
            $error("FAIL duty_hi_high got=%0d exp=%0d", hi, 9);
        end
        n_cmp++;
        assert (sy === 1) else begin
            n_err++;
            $error("FAIL duty_hi_sync got=%0d exp=%0d", sy, 1);
        end
`endif

        // Randomized operation
        for (int k = 0; k < 300; k++) begin
            shift          = ($urandom_range(0, 7) == 0);
            stretch        = NCH'($urandom_range(0, 3)) & NCH'({NCH{$urandom_range(0, 2) == 0}});
            resync         = ($urandom_range(0, 39) == 0);
            cfg_bus.cfg_we = ($urandom_range(0, 9) == 0);
            cfg_bus.cfg_ch = 1'($urandom_range(0, 1));
            cfg_bus.cfg_div = ($urandom_range(0, 3) == 0) ? DIVW'($urandom_range(0, 63))
                                                          : DIVW'($urandom_range(0, 9));
`ifdef CLOCKGEN_DUTY_EN
            cfg_bus.cfg_high = DIVW'($urandom_range(0, 12));
`endif
            step("random");
        end
        shift          = 1'b0;
        stretch        = '0;
        resync         = 1'b0;
        cfg_bus.cfg_we = 1'b0;

        // Mid-operation asynchronous reset with a pending write outstanding
        write_cfg(1, 5, "pre_reset_write");
        for (int k = 0; k < 3; k++) step("pre_reset");
        if (cfg_bus.pending == '0) write_cfg(0, 4, "pre_reset_write2");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(negedge clk);
        check_outputs("reset_hold");
        reset = 1'b0;
        for (int k = 0; k < 8; k++) step("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
